// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external RAM port between instruction fetch and the MEM stage.
// MEM normally wins; a starvation counter forces IF through after STARVE_LIMIT MEM wins.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SEL_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [SEL_WIDTH-1:0]  mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_done,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stallreq_if,
  output logic                  stallreq_mem,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [SEL_WIDTH-1:0]  ram_sel,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            dbg_state
);

  // Requester handshake: x_req is raised and held until x_done has been seen;
  // x_done pulses for one cycle, and x_req is ignored during that cycle so a
  // requester that drops req one cycle late never gets a second grant.
  // RAM side: ram_req and the ram_* payload stay stable until ram_ack=1.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_e;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e                  state_q;
  logic [CNT_W-1:0]        starve_cnt_q;
  logic                    ram_req_q, ram_we_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [SEL_WIDTH-1:0]    ram_sel_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;
  logic                    if_done_q, mem_done_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q, mem_rdata_q;

  logic                    if_pend, mem_pend, mem_wins, if_wins;
  logic [CNT_W-1:0]        starve_cnt_d;

  assign if_pend  = if_req & ~if_done_q;
  assign mem_pend = mem_req & ~mem_done_q;
  assign mem_wins = mem_pend & (~if_pend | (starve_cnt_q < LIMIT));
  assign if_wins  = if_pend & ~mem_wins;

  // Counts MEM wins taken while IF was waiting; saturates at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (if_pend) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= '0;
      ram_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_wins) begin
            state_q      <= GNT_MEM;
            starve_cnt_q <= starve_cnt_d;
            ram_req_q    <= 1'b1;
            ram_we_q     <= mem_we;
            ram_addr_q   <= mem_addr;
            ram_sel_q    <= mem_sel;
            ram_wdata_q  <= mem_wdata;
          end else if (if_wins) begin
            state_q      <= GNT_IF;
            starve_cnt_q <= '0;
            ram_req_q    <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= if_addr;
            ram_sel_q    <= '1;
            ram_wdata_q  <= '0;
          end
        end
        GNT_IF: begin
          if (ram_ack) begin
            state_q    <= IDLE;
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= ram_rdata;
          end
        end
        GNT_MEM: begin
          if (ram_ack) begin
            state_q    <= IDLE;
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            mem_done_q <= 1'b1;
            if (!ram_we_q) mem_rdata_q <= ram_rdata;
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_req_q <= 1'b0;
          ram_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req      = ram_req_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_sel      = ram_sel_q;
  assign ram_wdata    = ram_wdata_q;
  assign if_done      = if_done_q;
  assign mem_done     = mem_done_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req & ~if_done_q;
  assign stallreq_mem = mem_req & ~mem_done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LIM = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_IF   = 1;
  localparam int ST_MEM  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, ram_ack;
  logic [AW-1:0] if_addr, mem_addr;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_wdata, ram_rdata;
  logic          if_done, mem_done, stallreq_if, stallreq_mem;
  logic          ram_req, ram_we;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_sel;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Who owns the port, plus the values each output must show after the edge.
  int            m_owner;
  int            m_mem_wins;
  logic          m_req, m_we, m_if_done, m_mem_done;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_wdata, m_if_rdata, m_mem_rdata;
  bit            m_valid = 0;
  int            grant_log[$];

  // Scoreboard: addresses of granted transactions, popped when ram_req rises.
  logic [AW-1:0] exp_q[$];
  logic          prev_ram_req = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ifp, mp;
    if (rst) begin
      m_owner = ST_IDLE; m_mem_wins = 0;
      m_req = 0; m_we = 0; m_addr = '0; m_sel = '0; m_wdata = '0;
      m_if_done = 0; m_mem_done = 0; m_if_rdata = '0; m_mem_rdata = '0;
      m_valid = 1;
      exp_q.delete();
      return;
    end
    ifp = if_req && !m_if_done;
    mp  = mem_req && !m_mem_done;
    m_if_done = 0;
    m_mem_done = 0;
    if (m_owner == ST_IDLE) begin
      if (mp && (!ifp || m_mem_wins < LIM)) begin
        m_owner = ST_MEM; m_req = 1; m_we = mem_we;
        m_addr = mem_addr; m_sel = mem_sel; m_wdata = mem_wdata;
        m_mem_wins = ifp ? ((m_mem_wins + 1 > LIM) ? LIM : m_mem_wins + 1) : 0;
        exp_q.push_back(mem_addr);
        grant_log.push_back(ST_MEM);
      end else if (ifp) begin
        m_owner = ST_IF; m_req = 1; m_we = 0;
        m_addr = if_addr; m_sel = '1; m_wdata = '0;
        m_mem_wins = 0;
        exp_q.push_back(if_addr);
        grant_log.push_back(ST_IF);
      end
    end else if (ram_ack) begin
      if (m_owner == ST_IF) begin
        m_if_done = 1; m_if_rdata = ram_rdata;
      end else begin
        m_mem_done = 1;
        if (!m_we) m_mem_rdata = ram_rdata;
      end
      m_owner = ST_IDLE; m_req = 0; m_we = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("state", 64'(dbg_state), 64'(m_owner));
    check_val("ram_req", 64'(ram_req), 64'(m_req));
    check_val("ram_we", 64'(ram_we), 64'(m_we));
    check_val("ram_addr", 64'(ram_addr), 64'(m_addr));
    check_val("ram_sel", 64'(ram_sel), 64'(m_sel));
    check_val("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
    check_val("if_done", 64'(if_done), 64'(m_if_done));
    check_val("mem_done", 64'(mem_done), 64'(m_mem_done));
    check_val("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
    check_val("mem_rdata", 64'(mem_rdata), 64'(m_mem_rdata));
    if (ram_req && !prev_ram_req) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_grant", 64'(1), 64'(0));
      else check_val("sb_grant_addr", 64'(ram_addr), 64'(exp_q.pop_front()));
    end
    prev_ram_req = ram_req;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check combinational stalls on the current inputs, advance the
  // model, then check the registered outputs just after the edge.
  task automatic cycle();
    #1;
    if (m_valid) begin
      check_val("stallreq_if", 64'(stallreq_if), 64'(if_req & ~m_if_done));
      check_val("stallreq_mem", 64'(stallreq_mem), 64'(mem_req & ~m_mem_done));
    end
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    rst = 0; if_req = 0; mem_req = 0; mem_we = 0; ram_ack = 0;
    if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0; ram_rdata = '0;
  endtask

  // Returns the port to IDLE with no pending done pulse; bounded.
  task automatic drain();
    int n = 0;
    if_req = 0; mem_req = 0;
    while ((m_owner != ST_IDLE || m_if_done || m_mem_done) && n < 20) begin
      ram_ack = 1; cycle(); n++;
    end
    ram_ack = 0;
    if (n == 20) check_val("drain_timeout", 64'(1), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rdata_before;
    int n_if, n_mem;

    idle_inputs();
    rst = 1;
    cycle();

    // Reset held 2 cycles with ack and both requests high.
    if_req = 1; mem_req = 1; ram_ack = 1; mem_addr = 32'h40; if_addr = 32'h80;
    cycle(); cycle();
    check_val("reset_ram_req", 64'(ram_req), 64'(0));
    check_val("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 0; ram_ack = 0;
    cycle();
    check_val("first_grant_after_reset", 64'(ram_req), 64'(1));
    drain();

    // IF only, ack two cycles after grant.
    if_req = 1; if_addr = 32'h100;
    cycle();
    check_val("if_ram_addr", 64'(ram_addr), 64'(32'h100));
    check_val("if_ram_sel", 64'(ram_sel), 64'(4'b1111));
    cycle();
    ram_ack = 1; ram_rdata = 32'hDEADBEEF;
    cycle();
    check_val("if_done_pulse", 64'(if_done), 64'(1));
    check_val("if_rdata_dir", 64'(if_rdata), 64'(32'hDEADBEEF));
    ram_ack = 0;
    cycle();
    check_val("if_done_one_cycle", 64'(if_done), 64'(0));
    check_val("if_no_regrant", 64'(ram_req), 64'(0));
    drain();

    // Store held across three wait cycles.
    rdata_before = mem_rdata;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_sel = 4'b0011; mem_wdata = 32'h12345678;
    cycle();
    mem_addr = 32'hFFFF; mem_wdata = 32'h0;
    cycle(); cycle(); cycle();
    check_val("store_addr_held", 64'(ram_addr), 64'(32'h200));
    check_val("store_wdata_held", 64'(ram_wdata), 64'(32'h12345678));
    ram_ack = 1; ram_rdata = 32'hCAFEF00D;
    cycle();
    check_val("store_done", 64'(mem_done), 64'(1));
    check_val("store_rdata_kept", 64'(mem_rdata), 64'(rdata_before));
    ram_ack = 0;
    cycle();
    drain();

    // Contention: both requesters keep asking, RAM acks after one cycle.
    grant_log.delete();
    if_req = 1; mem_req = 1; mem_we = 0;
    for (int i = 0; i < 40; i++) begin
      mem_addr = 32'($urandom); if_addr = 32'($urandom); ram_rdata = 32'($urandom);
      ram_ack = m_req && (m_owner != ST_IDLE);
      cycle();
    end
    n_if = 0; n_mem = 0;
    foreach (grant_log[i]) if (grant_log[i] == ST_IF) n_if++; else n_mem++;
    check_val("contention_if_served", 64'(n_if > 0), 64'(1));
    check_val("contention_mem_served", 64'(n_mem > 0), 64'(1));
    drain();

    // Reset mid-access, then a late ack that must be ignored.
    mem_req = 1; mem_we = 0; mem_addr = 32'h300;
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0; mem_req = 0; ram_ack = 1;
    cycle();
    check_val("late_ack_no_done", 64'(mem_done), 64'(0));
    check_val("late_ack_no_req", 64'(ram_req), 64'(0));
    ram_ack = 0;
    cycle();

    // Random traffic; requests toggle freely, acks are random and may be spurious.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      if_req    = ($urandom_range(0, 3) != 0);
      mem_req   = ($urandom_range(0, 2) != 0);
      mem_we    = $urandom_range(0, 1);
      if_addr   = 32'($urandom);
      mem_addr  = 32'($urandom);
      mem_sel   = 4'($urandom);
      mem_wdata = 32'($urandom);
      ram_rdata = 32'($urandom);
      ram_ack   = (m_owner != ST_IDLE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cycle();
    end

    drain();
    check_val("sb_leftover", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
